// File: rtl/md_unit_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: op codes, default
// latencies and FSM state encoding.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  localparam int MD_WIDTH_DEF       = 32;
  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;
  localparam int MD_CNT_W           = 6;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface md_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, cancel, input busy, hi, lo);
  modport slave  (input start, op, a, b, cancel, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle mult/div unit with HI/LO registers. The result is computed at the
// issue edge and held in a pending register until the latency counter expires.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH       = MD_WIDTH_DEF,
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input logic      clk_i,
  input logic      reset_i,
  md_unit_if.slave md
);

  localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);
  localparam logic [WIDTH-1:0]    MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e               state_q, state_d;
  logic [MD_CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]      pend_q, pend_d;
  logic [WIDTH-1:0]        hi_q, hi_d, lo_q, lo_d;

  logic signed [2*WIDTH-1:0] a_sx, b_sx;
  logic [2*WIDTH-1:0]        prod_s, prod_u;
  logic                      div_zero, div_ovf;
  logic [WIDTH-1:0]          div_u_den, div_s_den;
  logic [WIDTH-1:0]          quo_s, rem_s, quo_u, rem_u;

  assign a_sx   = {{WIDTH{md.a[WIDTH-1]}}, md.a};
  assign b_sx   = {{WIDTH{md.b[WIDTH-1]}}, md.b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {{WIDTH{1'b0}}, md.a} * {{WIDTH{1'b0}}, md.b};

  // Divisors are forced to 1 in the special cases so the datapath never sees /0 or MIN/-1.
  assign div_zero  = (md.b == '0);
  assign div_ovf   = (md.a == MOST_NEG) && (md.b == '1);
  assign div_u_den = div_zero ? WIDTH'(1) : md.b;
  assign div_s_den = (div_zero || div_ovf) ? WIDTH'(1) : md.b;
  assign quo_s     = $signed(md.a) / $signed(div_s_den);
  assign rem_s     = $signed(md.a) % $signed(div_s_den);
  assign quo_u     = md.a / div_u_den;
  assign rem_u     = md.a % div_u_den;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (md.start && !md.cancel) begin
          case (md_op_e'(md.op))
            MD_MULT: begin
              pend_d  = prod_s;
              cnt_d   = MULT_LOAD;
              state_d = MD_RUN;
            end
            MD_MULTU: begin
              pend_d  = prod_u;
              cnt_d   = MULT_LOAD;
              state_d = MD_RUN;
            end
            MD_DIV: begin
              if (div_zero)     pend_d = {md.a, {WIDTH{1'b1}}};
              else if (div_ovf) pend_d = {{WIDTH{1'b0}}, MOST_NEG};
              else              pend_d = {rem_s, quo_s};
              cnt_d   = DIV_LOAD;
              state_d = MD_RUN;
            end
            MD_DIVU: begin
              if (div_zero) pend_d = {md.a, {WIDTH{1'b1}}};
              else          pend_d = {rem_u, quo_u};
              cnt_d   = DIV_LOAD;
              state_d = MD_RUN;
            end
            MD_MTHI: hi_d = md.a;
            MD_MTLO: lo_d = md.a;
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        if (md.cancel) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
          pend_d  = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == MD_CNT_W'(1)) begin
            hi_d    = pend_q[2*WIDTH-1:WIDTH];
            lo_d    = pend_q[WIDTH-1:0];
            state_d = MD_IDLE;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md.busy = (state_q == MD_RUN);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a vector table for single operations, then
// hand-written sequences for start-while-busy, cancel and reset mid-operation.
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  md_unit_if #(.WIDTH(32)) bus ();

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .md      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  logic [31:0] m_hi, m_lo;
  int          n;
  logic        hold_ok;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    vecs[0]  = '{"mult_neg2x3",   3'(MD_MULT),  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{"multu_max",     3'(MD_MULTU), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[2]  = '{"div_m7_2",      3'(MD_DIV),   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{"divu_by0",      3'(MD_DIVU),  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 10};
    vecs[4]  = '{"div_ovf",       3'(MD_DIV),   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5]  = '{"mthi",          3'(MD_MTHI),  32'h12345678, 32'h00000000, 32'h12345678, 32'h80000000, 0};
    vecs[6]  = '{"mtlo",          3'(MD_MTLO),  32'hCAFEF00D, 32'h00000000, 32'h12345678, 32'hCAFEF00D, 0};
    vecs[7]  = '{"divu_100_7",    3'(MD_DIVU),  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 10};
    vecs[8]  = '{"div_7_m2",      3'(MD_DIV),   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[9]  = '{"div_m7_by0",    3'(MD_DIV),   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 10};
    vecs[10] = '{"mult_max_m1",   3'(MD_MULT),  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 5};
    vecs[11] = '{"undef_op",      3'd6,         32'h11111111, 32'h22222222, 32'hFFFFFFFF, 32'h80000001, 0};

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op     = '0;
    bus.a      = '0;
    bus.b      = '0;
    bus.cancel = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_hi",   64'(bus.hi),   64'd0);
    check("reset_lo",   64'(bus.lo),   64'd0);
    m_hi = '0;
    m_lo = '0;

    for (int i = 0; i < NV; i++) begin
      bus.start = 1'b1;
      bus.op    = vecs[i].op;
      bus.a     = vecs[i].a;
      bus.b     = vecs[i].b;
      tick();
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      n       = 0;
      hold_ok = 1'b1;
      while (bus.busy && n < 100) begin
        if (bus.hi !== m_hi || bus.lo !== m_lo) hold_ok = 1'b0;
        tick();
        n++;
      end
      check({vecs[i].name, "_cycles"}, 64'(n), 64'(vecs[i].cyc));
      check({vecs[i].name, "_hold"},   64'(hold_ok), 64'd1);
      check({vecs[i].name, "_hi"},     64'(bus.hi), 64'(vecs[i].hi));
      check({vecs[i].name, "_lo"},     64'(bus.lo), 64'(vecs[i].lo));
      m_hi = vecs[i].hi;
      m_lo = vecs[i].lo;
    end

    // MTLO issued while a MULT is running must be dropped
    bus.start = 1'b1; bus.op = 3'(MD_MULT); bus.a = 32'd2; bus.b = 32'd3;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1; bus.op = 3'(MD_MTLO); bus.a = 32'hDEADBEEF;
    tick();
    bus.start = 1'b0;
    check("mtlo_busy_lo",   64'(bus.lo),   64'h80000001);
    check("mtlo_busy_busy", 64'(bus.busy), 64'd1);
    n = 2;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
    check("mtlo_busy_cycles", 64'(n),      64'd5);
    check("mtlo_busy_hi",     64'(bus.hi), 64'h0);
    check("mtlo_busy_lo2",    64'(bus.lo), 64'h6);

    // cancel on the 3rd busy cycle
    bus.start = 1'b1; bus.op = 3'(MD_MULT); bus.a = 32'd5; bus.b = 32'd5;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("cancel3_busy_pre", 64'(bus.busy), 64'd1);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check("cancel3_busy", 64'(bus.busy), 64'd0);
    repeat (8) tick();
    check("cancel3_hi",   64'(bus.hi), 64'h0);
    check("cancel3_lo",   64'(bus.lo), 64'h6);

    // cancel on the completion cycle
    bus.start = 1'b1; bus.op = 3'(MD_MULT); bus.a = 32'd5; bus.b = 32'd5;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    check("cancel5_busy_pre", 64'(bus.busy), 64'd1);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check("cancel5_busy", 64'(bus.busy), 64'd0);
    check("cancel5_hi",   64'(bus.hi),   64'h0);
    check("cancel5_lo",   64'(bus.lo),   64'h6);
    repeat (3) tick();
    check("cancel5_lo_late", 64'(bus.lo), 64'h6);

    // cancel together with start in IDLE suppresses the start
    bus.cancel = 1'b1;
    bus.start  = 1'b1; bus.op = 3'(MD_MTHI); bus.a = 32'h00000055;
    tick();
    check("cancel_mthi_hi", 64'(bus.hi), 64'h0);
    bus.op = 3'(MD_MULT); bus.b = 32'd9;
    tick();
    check("cancel_mult_busy", 64'(bus.busy), 64'd0);
    bus.cancel = 1'b0;
    bus.start  = 1'b0;
    tick();
    check("cancel_idle_lo", 64'(bus.lo), 64'h6);

    // reset on the 2nd busy cycle of a DIV
    bus.start = 1'b1; bus.op = 3'(MD_DIV); bus.a = 32'd100; bus.b = 32'd7;
    tick();
    bus.start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_hi",   64'(bus.hi),   64'h0);
    check("rst_mid_lo",   64'(bus.lo),   64'h0);
    repeat (12) tick();
    check("rst_late_busy", 64'(bus.busy), 64'd0);
    check("rst_late_hi",   64'(bus.hi),   64'h0);
    check("rst_late_lo",   64'(bus.lo),   64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit with HI/LO registers for the five-stage pipelined CPU.
- Sits in the EX stage, beside the ALU. It takes forwarded RS/RT operands.
- Runs mult/multu/div/divu over a configurable number of cycles and accepts mthi/mtlo writes.
- Exposes `busy` so the hazard controller can stall dependent MD instructions in ID.
- Supports a cancel input so an in-flight operation can be discarded when the pipeline is flushed.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..63).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..63).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  issue strobe for the op in EX; only effective when not busy.
- op  input  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO (codes in shared constants).
- A  input  WIDTH  forwarded RS operand (mthi/mtlo data source).
- B  input  WIDTH  forwarded RT operand.
- cancel  input  1  aborts the in-flight operation (pipeline flush).
- busy  output  1  high while an operation is in flight.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- Reset: on a clk edge with reset=1: busy=0, HI=0, LO=0, counter=0, pending result discarded. Reset overrides start and cancel. Reset mid-operation aborts the operation.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, counter counts down).
- IDLE, start=1, op MULT/MULTU:
  - At the sampling edge, compute the full 2*WIDTH product into a result register.
  - Load counter with MULT_CYCLES and go to RUN.
  - Signed product for MULT, unsigned for MULTU.
- IDLE, start=1, op DIV/DIVU:
  - Quotient goes to the pending LO, remainder to the pending HI. Load DIV_CYCLES.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero: pending HI = A, pending LO = all ones.
  - Signed overflow (A = most-negative, B = -1): LO = most-negative, HI = 0.
- IDLE, start=1, op MTHI/MTLO:
  - At the sampling edge HI (or LO) = A. The other register is unchanged.
  - busy stays 0.
- IDLE, start=1, undefined op: no effect.
- RUN:
  - counter decrements on each edge.
  - On the edge where counter goes from 1 to 0: HI/LO take the pending result and the unit returns to IDLE.
  - Net timing: busy is high for exactly N cycles after the sampling edge (N = MULT_CYCLES or DIV_CYCLES), and HI/LO update on the same edge busy falls.
  - HI/LO hold their previous values for the whole of RUN.
- start while busy: ignored. The controller guarantees stall, but the unit must not corrupt state.
- cancel:
  - In RUN: return to IDLE on that edge, pending result discarded, HI/LO unchanged.
  - cancel and start in the same IDLE cycle: start is ignored, including mthi/mtlo.
  - cancel in IDLE without start: no effect.
- Completion edge with cancel=1: cancel wins, HI/LO unchanged.
- Operands are sampled only at the start edge; later changes on A/B have no effect.
- Stall contract for the controller:
  - stall an MD-class instruction (mult/div/mthi/mtlo/mfhi/mflo) in ID while busy=1, or while start=1 with op MULT/MULTU/DIV/DIVU in EX.
  - mfhi/mflo read HI/LO directly in EX.

Decomposition:
- Shared constants file (alongside the existing macro definitions):
  - MD op codes: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5.
  - Default latency constants.
- The Decoder produces op/start from the ID-stage IR. These are carried through the ID/EX register.
- No sub-module: the result computation, counter FSM and HI/LO registers fit in one block.
- An iterative divider sub-module (md_div_iter) is optional later. It must preserve the cycle contract above.

Test Plan:
- Reset then MULT A=0xFFFFFFFE (-2), B=3, MULT_CYCLES=5 -> busy high for 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA on the edge busy falls; HI/LO=0 before that.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
- DIV A=-7 (0xFFFFFFF9), B=2, DIV_CYCLES=10 -> after 10 busy cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Then DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=7. Then DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI A=0x12345678 while idle -> HI=0x12345678 next edge, busy stays 0, LO unchanged. Issue start with MTLO during a RUN -> ignored, LO unchanged.
- Start MULT; cancel on 3rd busy cycle -> busy falls that edge, HI/LO keep pre-start values. Repeat with cancel on the completion cycle -> same result.
- Assert reset on the 2nd busy cycle of a DIV -> busy=0, HI=LO=0 next edge; no late result write afterwards.
